// File: rtl/ntt_result_buffer_pkg.sv
// ntt_result_buffer_pkg
// Shared definitions for the NTT result buffer and the memory wrapper that
// feeds it: default widths, the wrapper write-address width, and the drain
// FSM state encoding.
package ntt_result_buffer_pkg;

    localparam int LOGQ_DEFAULT = 64;
    localparam int LOGN_DEFAULT = 4;

    // Wrapper write-address bus width; the wrapper addresses at least 512
    // words plus one extra bit, independent of the polynomial length.
    function automatic int calc_addr_w(input int logn);
        return ((logn < 9) ? 9 : logn) + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } drain_state_t;

endpackage

// File: rtl/ntt_result_buffer_if.sv
// ntt_result_buffer_if
// Bundles the capture side (wrapper write port + finish) and the streaming
// side (valid/ready output plus sticky error flags) of the result buffer.
//   slave  : the buffer itself
//   master : the environment (wrapper and consumer)
interface ntt_result_buffer_if
    import ntt_result_buffer_pkg::*;
#(
    parameter int LOGQ   = LOGQ_DEFAULT,
    parameter int LOGN   = LOGN_DEFAULT,
    parameter int ADDR_W = calc_addr_w(LOGN)
);
    logic              ntt_wea;
    logic [ADDR_W-1:0] ntt_write_address;
    logic [LOGQ-1:0]   ntt_data_in;
    logic              ntt_finish;
    logic              capture_ready;
    logic              m_valid;
    logic              m_ready;
    logic [LOGQ-1:0]   m_data;
    logic [LOGN-1:0]   m_index;
    logic              m_last;
    logic              err_overflow;
    logic              err_addr;

    modport slave (
        input  ntt_wea, ntt_write_address, ntt_data_in, ntt_finish, m_ready,
        output capture_ready, m_valid, m_data, m_index, m_last,
               err_overflow, err_addr
    );

    modport master (
        output ntt_wea, ntt_write_address, ntt_data_in, ntt_finish, m_ready,
        input  capture_ready, m_valid, m_data, m_index, m_last,
               err_overflow, err_addr
    );

endinterface

// File: rtl/ntt_result_bram.sv
// ntt_result_bram
// Simple dual-port RAM holding both banks (2*N x LOGQ); the bank select is
// the address MSB. Reads are registered with DELAY_BRAM cycles of latency.
// Contents are never cleared.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   {bank, index} write address
//   wdata  in   write data
//   re     in   read enable (captures raddr)
//   raddr  in   {bank, index} read address
//   rdata  out  read data, DELAY_BRAM cycles after re
module ntt_result_bram
    import ntt_result_buffer_pkg::*;
#(
    parameter int LOGQ       = LOGQ_DEFAULT,
    parameter int LOGN       = LOGN_DEFAULT,
    parameter int DELAY_BRAM = 1
) (
    input  logic            clk,
    input  logic            we,
    input  logic [LOGN:0]   waddr,
    input  logic [LOGQ-1:0] wdata,
    input  logic            re,
    input  logic [LOGN:0]   raddr,
    output logic [LOGQ-1:0] rdata
);
    localparam int DEPTH = 2 << LOGN;

    logic [LOGQ-1:0] mem  [DEPTH];
    logic [LOGQ-1:0] pipe [DELAY_BRAM];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            pipe[0] <= mem[raddr];
        end
        // Later stages shift freely; validity is tracked by the reader.
        for (int i = 1; i < DELAY_BRAM; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign rdata = pipe[DELAY_BRAM-1];

endmodule

// File: rtl/ntt_result_buffer.sv
// ntt_result_buffer
// Collects the scattered writes of one NTT/INTT run into a natural-order
// bank, then streams the polynomial out in index order 0..N-1. Two banks let
// the next run be captured while the previous one drains.
// Ports:
//   clk   in     clock
//   rst   in     synchronous active-high reset
//   bus   slave  ntt_result_buffer_if: wrapper write port, finish,
//                capture_ready, m_valid/m_ready/m_data/m_index/m_last,
//                err_overflow, err_addr
//
// Drain FSM (read-issue side):
//   state     | meaning
//   ST_IDLE   | nothing to read; issue index 0 as soon as the bank fills
//   ST_FETCH  | issuing reads of iss_bank, rd_idx is the next index
//   ST_STREAM | all reads issued, waiting for the tail to be handshaken
//
// The issue side (iss_bank) may run ahead into the next bank while the tail
// of the previous bank still sits in the output register/skid, which keeps
// back-to-back runs contiguous. rd_bank follows the handshakes and owns the
// full-flag release.
module ntt_result_buffer
    import ntt_result_buffer_pkg::*;
#(
    parameter int LOGQ       = LOGQ_DEFAULT,
    parameter int LOGN       = LOGN_DEFAULT,
    parameter int DELAY_BRAM = 1,
    parameter int ADDR_W     = calc_addr_w(LOGN)
) (
    input  logic                clk,
    input  logic                rst,
    ntt_result_buffer_if.slave  bus
);
    localparam int N     = 1 << LOGN;
    // Output register plus skid, sized so reads in flight always have a slot.
    localparam int DEPTH = DELAY_BRAM + 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Capture / bank flags
    logic [1:0]        full;
    logic [1:0]        full_n;
    logic              wr_bank, wr_bank_n;
    logic              rd_bank;
    logic              finish_q;
    logic              capture_ready_q;
    logic              err_overflow_q;
    logic              err_addr_q;
    logic              addr_ok;
    logic              wr_en;
    logic              fin_edge;
    logic              close_ok;

    // Read issue
    drain_state_t      state;
    logic              iss_bank;
    logic [LOGN-1:0]   rd_idx;
    logic [LOGN-1:0]   rd_sel_idx;
    logic              rd_en;
    logic              room;
    int                inflight;
    logic [DELAY_BRAM-1:0] vld_pipe;
    logic [LOGQ-1:0]   ram_rdata;

    // Output register + skid
    logic [LOGQ-1:0]   data_q [DEPTH];
    logic [LOGQ-1:0]   data_n [DEPTH];
    logic [OCC_W-1:0]  occ, occ_n, wr_pos;
    logic              push, pop;
    logic              drain_done;
    logic              m_valid_q;
    logic              m_last_q;
    logic [LOGN-1:0]   out_idx;

    assign addr_ok    = bus.ntt_write_address < ADDR_W'(N);
    assign wr_en      = bus.ntt_wea & capture_ready_q & addr_ok;
    assign fin_edge   = bus.ntt_finish & ~finish_q;
    // A close with the write bank still full can only follow an overflow.
    assign close_ok   = fin_edge & ~full[wr_bank];
    assign pop        = m_valid_q & bus.m_ready;
    assign drain_done = pop & (out_idx == LOGN'(N - 1));
    assign push       = vld_pipe[DELAY_BRAM-1];

    ntt_result_bram #(
        .LOGQ       (LOGQ),
        .LOGN       (LOGN),
        .DELAY_BRAM (DELAY_BRAM)
    ) u_bram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank, bus.ntt_write_address[LOGN-1:0]}),
        .wdata (bus.ntt_data_in),
        .re    (rd_en),
        .raddr ({iss_bank, rd_sel_idx}),
        .rdata (ram_rdata)
    );

    // ---------------- bank flags ----------------
    always_comb begin
        full_n    = full;
        wr_bank_n = wr_bank;
        if (close_ok) begin
            full_n[wr_bank] = 1'b1;
            wr_bank_n       = ~wr_bank;
        end
        // close_ok needs the write bank empty, drain_done needs the read bank
        // full, so these never target the same bank.
        if (drain_done) begin
            full_n[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full            <= 2'b00;
            wr_bank         <= 1'b0;
            rd_bank         <= 1'b0;
            finish_q        <= 1'b0;
            capture_ready_q <= 1'b1;
            err_overflow_q  <= 1'b0;
            err_addr_q      <= 1'b0;
        end else begin
            finish_q        <= bus.ntt_finish;
            full            <= full_n;
            wr_bank         <= wr_bank_n;
            capture_ready_q <= ~full_n[wr_bank_n];
            if (drain_done) begin
                rd_bank <= ~rd_bank;
            end
            if ((bus.ntt_wea & ~capture_ready_q) | (fin_edge & full[wr_bank])) begin
                err_overflow_q <= 1'b1;
            end
            if (bus.ntt_wea & ~addr_ok) begin
                err_addr_q <= 1'b1;
            end
        end
    end

    // ---------------- read issue ----------------
    // Issue only when the word is guaranteed a slot in the output register
    // or skid once it returns from the RAM.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < DELAY_BRAM; i++) begin
            inflight = inflight + int'(vld_pipe[i]);
        end
        room       = (int'(occ) + inflight - int'(pop)) < DEPTH;
        rd_en      = 1'b0;
        rd_sel_idx = rd_idx;
        case (state)
            ST_FETCH: rd_en = room;
            default: begin
                // Index 0 goes out in the same cycle the bank is seen full.
                if (full[iss_bank] && room) begin
                    rd_en      = 1'b1;
                    rd_sel_idx = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rd_idx   <= '0;
            iss_bank <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_en) begin
                        state  <= ST_FETCH;
                        rd_idx <= LOGN'(1);
                    end
                end
                ST_FETCH: begin
                    if (rd_en) begin
                        if (rd_idx == LOGN'(N - 1)) begin
                            iss_bank <= ~iss_bank;
                            rd_idx   <= '0;
                            state    <= full[~iss_bank] ? ST_FETCH : ST_STREAM;
                        end else begin
                            rd_idx <= rd_idx + LOGN'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    if (rd_en) begin
                        state  <= ST_FETCH;
                        rd_idx <= LOGN'(1);
                    end else if (drain_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- output register + skid ----------------
    // data_q[0] is the output register; a pop shifts the queue down and a
    // returning read lands behind whatever remains.
    always_comb begin
        wr_pos = occ - OCC_W'(pop);
        occ_n  = occ + OCC_W'(push) - OCC_W'(pop);
        data_n = data_q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                data_n[i] = data_q[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_pos == OCC_W'(i)) begin
                    data_n[i] = ram_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            occ       <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            out_idx   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= rd_en;
            for (int i = 1; i < DELAY_BRAM; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
            occ       <= occ_n;
            m_valid_q <= (occ_n != '0);
            data_q    <= data_n;
            if (pop) begin
                // Natural wrap back to 0 after N-1 starts the next run.
                out_idx  <= out_idx + LOGN'(1);
                m_last_q <= ((out_idx + LOGN'(1)) == LOGN'(N - 1));
            end
        end
    end

    assign bus.capture_ready = capture_ready_q;
    assign bus.m_valid       = m_valid_q;
    assign bus.m_data        = data_q[0];
    assign bus.m_index       = out_idx;
    assign bus.m_last        = m_last_q;
    assign bus.err_overflow  = err_overflow_q;
    assign bus.err_addr      = err_addr_q;

endmodule

// File: tb/tb_ntt_result_buffer.sv
// Directed bench for ntt_result_buffer (LOGN=4, LOGQ=64, DELAY_BRAM=1).
module tb_ntt_result_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   span;
    logic [63:0] exp_mem [32];

    always #5 clk = ~clk;

    ntt_result_buffer_if #(.LOGQ(64), .LOGN(4)) bus ();

    ntt_result_buffer #(
        .LOGQ       (64),
        .LOGN       (4),
        .DELAY_BRAM (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Writes exp_mem[off+a] to address a in bit-reversed order, then pulses finish.
    task automatic cap_run(input int off, input bit skip0);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] a;
            a = bitrev4(4'(k));
            if (!(skip0 && a == 4'd0)) begin
                bus.ntt_wea           = 1'b1;
                bus.ntt_write_address = 10'(a);
                bus.ntt_data_in       = exp_mem[off + int'(a)];
                step();
            end
        end
        bus.ntt_wea    = 1'b0;
        bus.ntt_finish = 1'b1;
        step();
        bus.ntt_finish = 1'b0;
    endtask

    // Consumes nwords against exp_mem; pat[t%4] drives m_ready. span is the
    // number of cycles from first valid to just after the last handshake.
    task automatic drain(input int nwords, input logic [3:0] pat, output int span_o);
        int got;
        int t;
        int t_first;
        got     = 0;
        t       = 0;
        t_first = -1;
        while (got < nwords && t < 400) begin
            bus.m_ready = pat[t % 4];
            if (bus.m_valid) begin
                if (t_first < 0) t_first = t;
                if (bus.m_ready) begin
                    chk("drain_data", bus.m_data, exp_mem[got]);
                    chk("drain_index", 64'(bus.m_index), 64'(got % 16));
                    chk("drain_last", 64'(bus.m_last), 64'((got % 16) == 15));
                    got++;
                end else begin
                    chk("stall_data", bus.m_data, exp_mem[got]);
                end
            end
            step();
            t++;
        end
        chk("drain_count", 64'(got), 64'(nwords));
        span_o = (t_first < 0) ? -1 : t - t_first;
    endtask

    initial begin
        bus.ntt_wea           = 1'b0;
        bus.ntt_write_address = '0;
        bus.ntt_data_in       = '0;
        bus.ntt_finish        = 1'b0;
        bus.m_ready           = 1'b0;
        repeat (3) step();

        chk("rst_capture_ready", 64'(bus.capture_ready), 64'd1);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_data", bus.m_data, 64'd0);
        chk("rst_m_index", 64'(bus.m_index), 64'd0);
        chk("rst_m_last", 64'(bus.m_last), 64'd0);
        chk("rst_err_overflow", 64'(bus.err_overflow), 64'd0);
        chk("rst_err_addr", 64'(bus.err_addr), 64'd0);
        rst = 1'b0;
        step();

        // Run 1: data 3*i, m_ready held high.
        for (int i = 0; i < 16; i++) exp_mem[i] = 64'(3 * i);
        bus.m_ready = 1'b1;
        cap_run(0, 1'b0);
        chk("t1_valid_e0", 64'(bus.m_valid), 64'd0);
        step();
        chk("t1_valid_e1", 64'(bus.m_valid), 64'd0);
        step();
        chk("t1_valid_e2", 64'(bus.m_valid), 64'd1);
        drain(16, 4'b1111, span);
        chk("t1_span", 64'(span), 64'd16);
        chk("t1_idle", 64'(bus.m_valid), 64'd0);

        // Run 2: same data, m_ready pattern 1,0,0,1.
        bus.m_ready = 1'b0;
        cap_run(0, 1'b0);
        drain(16, 4'b1001, span);
        chk("t2_idle", 64'(bus.m_valid), 64'd0);

        // Two runs captured before any draining.
        for (int i = 0; i < 16; i++) begin
            exp_mem[i]      = 64'(i);
            exp_mem[16 + i] = 64'h100 + 64'(i);
        end
        bus.m_ready = 1'b0;
        cap_run(0, 1'b0);
        chk("t3_cr_after1", 64'(bus.capture_ready), 64'd1);
        cap_run(16, 1'b0);
        chk("t3_cr_after2", 64'(bus.capture_ready), 64'd0);

        // Write while both banks are full.
        bus.ntt_wea           = 1'b1;
        bus.ntt_write_address = 10'd5;
        bus.ntt_data_in       = 64'hDEAD;
        step();
        bus.ntt_wea = 1'b0;
        chk("t4_err_overflow", 64'(bus.err_overflow), 64'd1);
        chk("t4_err_addr", 64'(bus.err_addr), 64'd0);

        drain(32, 4'b1111, span);
        chk("t3_span", 64'(span), 64'd32);
        chk("t3_idle", 64'(bus.m_valid), 64'd0);
        chk("t3_cr_free", 64'(bus.capture_ready), 64'd1);

        // Out-of-range address; entry 0 is left stale (0 from the previous run).
        bus.m_ready           = 1'b0;
        bus.ntt_wea           = 1'b1;
        bus.ntt_write_address = 10'd16;
        bus.ntt_data_in       = 64'hBAD;
        step();
        bus.ntt_wea = 1'b0;
        chk("t5_err_addr", 64'(bus.err_addr), 64'd1);
        chk("t5_err_overflow_sticky", 64'(bus.err_overflow), 64'd1);
        exp_mem[0] = 64'd0;
        for (int i = 1; i < 16; i++) exp_mem[i] = 64'h200 + 64'(i);
        cap_run(0, 1'b1);
        drain(16, 4'b1111, span);
        chk("t5_span", 64'(span), 64'd16);

        // Reset in the middle of a drain.
        for (int i = 0; i < 16; i++) exp_mem[i] = 64'h300 + 64'(i);
        bus.m_ready = 1'b0;
        cap_run(0, 1'b0);
        drain(7, 4'b1111, span);
        chk("t6_valid_at_7", 64'(bus.m_valid), 64'd1);
        chk("t6_index_at_7", 64'(bus.m_index), 64'd7);
        bus.m_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_valid", 64'(bus.m_valid), 64'd0);
        chk("t6_rst_cr", 64'(bus.capture_ready), 64'd1);
        chk("t6_rst_index", 64'(bus.m_index), 64'd0);
        chk("t6_rst_err_overflow", 64'(bus.err_overflow), 64'd0);
        chk("t6_rst_err_addr", 64'(bus.err_addr), 64'd0);
        for (int i = 0; i < 16; i++) exp_mem[i] = 64'hFFFF_FFFF_0000_0000 | 64'(i);
        cap_run(0, 1'b0);
        drain(16, 4'b1111, span);
        chk("t6_span", 64'(span), 64'd16);
        chk("t6_idle", 64'(bus.m_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_result_buffer.md
Name: ntt_result_buffer

Overview:
- Downstream stage of ntt_memory_wrapper. Captures the wrapper's scattered write-port output (write_address, wea, data_out) for one NTT/INTT run into a natural-order buffer.
- Once the wrapper pulses finish, streams the polynomial out in index order 0..N-1 on a valid/ready interface.
- Double-banked, so the next transform can be captured while the previous one drains.

Parameters:
- LOGQ, 64, coefficient width.
- LOGN, 4, log2 of polynomial length; N = 2**LOGN.
- DELAY_BRAM, 1, bank read latency in cycles (1 or 2). Drain pipeline depth tracks it.
- ADDR_W, ((LOGN<9)?9:LOGN)+1, width of the wrapper write-address bus.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- ntt_wea  in  1  wrapper write enable.
- ntt_write_address  in  ADDR_W  wrapper write address.
- ntt_data_in  in  LOGQ  wrapper data_out.
- ntt_finish  in  1  wrapper finish; rising edge closes the run.
- capture_ready  out  1  a bank is free to accept writes.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word when m_valid and m_ready are both high.
- m_data  out  LOGQ  coefficient.
- m_index  out  LOGN  coefficient index of m_data.
- m_last  out  1  high with index N-1.
- err_overflow  out  1  sticky: a write arrived while no bank was free.
- err_addr  out  1  sticky: a write arrived with address >= N.

Behaviour:
- Reset (sync, active-high): banks empty, wr_bank=0, rd_bank=0, capture_ready=1, m_valid=0, m_data=0, m_index=0, m_last=0, both err flags 0, finish edge register 0. RAM contents are not cleared. Reset mid-capture or mid-drain abandons the run with no output.
- Capture:
  - On each cycle with ntt_wea=1 and capture_ready=1 and ntt_write_address < N, write bank[wr_bank][addr[LOGN-1:0]] <= ntt_data_in.
  - A write with address >= N is dropped and sets err_addr.
  - A write with capture_ready=0 is dropped and sets err_overflow.
  - Later writes to the same address overwrite.
- Close:
  - finish_q registers ntt_finish. A rising edge (ntt_finish & ~finish_q) marks bank[wr_bank] full and toggles wr_bank.
  - capture_ready is registered and equals "bank[new wr_bank] is empty".
  - A finish edge with no writes since the last close still marks the bank full and drains stale contents.
- Drain FSM:
  - IDLE: if bank[rd_bank] is full, go to FETCH with rd_idx=0.
  - FETCH: issue reads ahead. The first m_valid appears DELAY_BRAM+1 cycles after the full flag is set.
  - STREAM: an output register plus a one-entry skid keeps 1 word/cycle while m_ready=1. m_valid, m_data, m_index and m_last hold stable while m_valid=1 and m_ready=0.
  - After the handshake on index N-1: bank[rd_bank] marked empty, rd_bank toggles. If the other bank is already full, go to FETCH with no idle cycle; otherwise go to IDLE.
- Simultaneous events:
  - Final-word handshake in the same cycle as a finish edge: both flag updates apply. A freed bank becomes capture-available the next cycle.
  - A finish edge while both banks are full cannot occur without a prior overflow. It is ignored: no toggle, and err_overflow is set.
- No arithmetic on data. Index wrap: rd_idx is LOGN bits, and the run ends at N-1, never wrapping into the next bank.

Decomposition:
- Shared header/package holds:
  - the ADDR_W expression, also used by ntt_memory_wrapper;
  - the drain FSM state encodings IDLE=0, FETCH=1, STREAM=2;
  - default LOGQ/LOGN.
- One sub-module, ntt_result_bram: simple dual-port RAM of 2*N x LOGQ, bank select as the address MSB, registered read with latency DELAY_BRAM. The top holds flags, FSM and the skid buffer.

Test Plan:
- LOGN=4, q=0xFFFFFFFF00000001. Wrapper writes data=k*3 at bit-reversed addresses 0..15, pulses finish, m_ready=1 held -> 16 words in order with m_data=3*i and m_index=i, m_last only at i=15. First m_valid 2 cycles after the finish edge (DELAY_BRAM=1).
- Same capture with m_ready toggling 1,0,0,1 -> no word lost or duplicated; m_data is stable during stalls.
- Two runs back to back (values i and 0x100+i), m_ready=0 until both are finished -> capture_ready goes 0 after the 2nd finish. With m_ready=1, run 1 then run 2 stream contiguously, 32 consecutive valid cycles.
- While both banks are full, wea with address 5, data 0xDEAD -> err_overflow=1; drained data unchanged.
- Write to address 16 -> err_addr=1; no bank entry is modified.
- Assert rst at drain index 7 -> next cycle m_valid=0, capture_ready=1, and a new run drains from index 0 correctly.
